sha2_stream_core: RTL and testbench
===================================

// Module: sha2_stream_core
// PURPOSE
//  Byte-stream SHA-224/SHA-256 engine: accepts a message of any length (1..2^LEN_W-1 bytes) over a
//  valid/ready byte interface and pads it in hardware, with multi-block chaining and 64-bit length.
//  Streams the digest out in OUT_W-bit chunks with backpressure. Sits between the tile input bus and the result port.
// PARAMETERS
//  OUT_W    8   digest chunk width; legal values 8 or 32
//  SHA224   0   1: SHA-224 IV, 7-word (224-bit) digest; 0: SHA-256 IV, 8-word digest
//  LEN_W    32  message byte-counter width; bit-length field = {zeros, byte_cnt, 3'b000}
// PORTS
//  clk        in   1      clock
//  reset_n    in   1      async active-low reset
//  soft_clr   in   1      sync abort: flush state, reload IV, return to IDLE
//  in_data    in   8      message byte
//  in_valid   in   1      in_data valid
//  in_last    in   1      qualifies in_data as final message byte
//  in_ready   out  1      core accepts a byte this cycle
//  out_data   out  OUT_W  digest chunk, big-endian, H0 MSB first
//  out_valid  out  1      out_data valid
//  out_last   out  1      final digest chunk
//  out_ready  in   1      sink accepts chunk
//  busy       out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (reset_n low, async): state=IDLE; H0..H7=IV; counters 0; out_data=0; out_valid=0; out_last=0;
//   busy=0. in_ready=1 immediately after release (decoded from state).
//  Handshake: byte taken when in_valid&&in_ready. Chunk retired when out_valid&&out_ready.
//   out_data/out_last hold stable while out_valid&&!out_ready.
//  States:
//   IDLE:  in_ready=1. First accepted byte -> LOAD.
//   LOAD:  in_ready=1; bytes shift MSB-first into the 16x32 W window; blk_cnt++ and msg_cnt++ per byte.
//          64th byte without in_last -> ROUND (chain=1). Any byte with in_last -> PAD.
//   PAD:   in_ready=0; inserts 1 byte/cycle: 0x80 once, then 0x00 up to blk_cnt=56, then 8 length bytes.
//          If 0x80 lands at blk_cnt>=56: zero-fill to 64 -> ROUND with extra=1.
//          The extra block is 56 zeros + length. Final block complete -> ROUND (final=1).
//          in_last on a 64-byte-aligned byte: block goes to ROUND first, then a full pad block follows.
//   ROUND: 64 cycles, one round/cycle. W[t] for t>=16 computed in place on the rolling 16-word window.
//          K from a 64-entry case ROM; a..h initialised from H on ROUND entry.
//   UPDATE: 1 cycle, Hi<=Hi+working var (mod 2^32). final -> OUTPUT; extra -> PAD; else -> LOAD (blk_cnt=0).
//   OUTPUT: out_valid=1; chunks = (SHA224?7:8)*32/OUT_W. out_last on the final chunk.
//          Retiring the final chunk -> IDLE: H=IV, counters 0, out_valid=0 on the next cycle.
//  Latency: 1-block message of n bytes (n<=55): last byte accepted at cycle c.
//   PAD covers cycles c+1..c+64-n, ROUND the next 64 cycles, UPDATE 1 cycle.
//   out_valid rises the cycle after UPDATE.
//  in_ready=0 in PAD/ROUND/UPDATE/OUTPUT. in_valid in those states is ignored, not queued.
//  soft_clr has priority over all activity in any state. Effect equals reset except it is synchronous.
//   A byte offered in the same cycle is dropped.
//  msg_cnt wraps silently at 2^LEN_W. Zero-length messages are not supported (in_last needs a byte).
//  All adds are 32-bit modulo. Rotations are exact (no shift-OR mixing with sign or width spill).
// TESTING
//  SHA256 "abc" (OUT_W=8) -> 32 chunks ba 78 16 bf .. f2 00 15 ad; out_last on the 32nd chunk;
//   out_valid 61+64+1 cycles after the last byte.
//  SHA256 56-byte "abcdbcde...nopq" (two-block pad path) -> 248d6a61 d20638b8 e5c02693 0c3e6039
//   a33ce459 64ff2167 f6ecedd4 19db06c1.
//  SHA224 "abc", OUT_W=32 -> 7 words 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
//   No 8th word.
//  Backpressure: drop out_ready for 5 cycles mid-digest and toggle in_valid during ROUND
//   -> out_data held, no chunk lost/duplicated, no bytes absorbed.
//  Back-to-back "abc" twice -> identical digests (IV reload). 64-byte message -> extra pad block processed.
//  Async reset mid-ROUND and soft_clr mid-LOAD -> outputs at reset values; next "abc" hashes correctly.

Source files
------------

// File: rtl/sha2_stream_core_if.sv
// Byte-in / chunk-out stream bundle for sha2_stream_core.
interface sha2_stream_core_if #(
  parameter int unsigned OUT_W = 8
) ();
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  // Producer of message bytes and consumer of digest chunks.
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  // The hashing core.
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/sha2_stream_core.sv
// Byte-stream SHA-224/SHA-256 core: absorbs a message byte by byte, pads it in
// hardware (0x80, zero fill, 64-bit bit length), runs one round per cycle and
// streams the digest out in OUT_W-bit chunks, H0 MSB first.
module sha2_stream_core #(
  parameter int unsigned OUT_W  = 8,
  parameter bit          SHA224 = 1'b0,
  parameter int unsigned LEN_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              soft_clr,
  output logic              busy,
  sha2_stream_core_if.slave bus
);
  localparam int unsigned N_CHUNK = (SHA224 ? 7 : 8) * 32 / OUT_W;
  localparam int unsigned IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

  localparam logic [31:0] IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] IV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_ROUND, S_UPDATE, S_OUTPUT} state_t;
  state_t state, nxt;

  logic [31:0]      h [8];
  logic [31:0]      v [8];
  logic [31:0]      w [16];
  logic [5:0]       blk_cnt, rnd;
  logic [LEN_W-1:0] msg_cnt;
  logic [IDX_W-1:0] out_idx;
  logic             p80, extra, fin;
  logic             take, blk_end, last_chunk, done, shift_en;
  logic [7:0]       pad_byte, sh_byte;
  logic [63:0]      len64;
  logic [31:0]      t1, t2, w_new;
  logic [255:0]     dig;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] t);
    k_rom = '0;
    case (t)
      6'd0:  k_rom = 32'h428a2f98; 6'd1:  k_rom = 32'h71374491; 6'd2:  k_rom = 32'hb5c0fbcf; 6'd3:  k_rom = 32'he9b5dba5;
      6'd4:  k_rom = 32'h3956c25b; 6'd5:  k_rom = 32'h59f111f1; 6'd6:  k_rom = 32'h923f82a4; 6'd7:  k_rom = 32'hab1c5ed5;
      6'd8:  k_rom = 32'hd807aa98; 6'd9:  k_rom = 32'h12835b01; 6'd10: k_rom = 32'h243185be; 6'd11: k_rom = 32'h550c7dc3;
      6'd12: k_rom = 32'h72be5d74; 6'd13: k_rom = 32'h80deb1fe; 6'd14: k_rom = 32'h9bdc06a7; 6'd15: k_rom = 32'hc19bf174;
      6'd16: k_rom = 32'he49b69c1; 6'd17: k_rom = 32'hefbe4786; 6'd18: k_rom = 32'h0fc19dc6; 6'd19: k_rom = 32'h240ca1cc;
      6'd20: k_rom = 32'h2de92c6f; 6'd21: k_rom = 32'h4a7484aa; 6'd22: k_rom = 32'h5cb0a9dc; 6'd23: k_rom = 32'h76f988da;
      6'd24: k_rom = 32'h983e5152; 6'd25: k_rom = 32'ha831c66d; 6'd26: k_rom = 32'hb00327c8; 6'd27: k_rom = 32'hbf597fc7;
      6'd28: k_rom = 32'hc6e00bf3; 6'd29: k_rom = 32'hd5a79147; 6'd30: k_rom = 32'h06ca6351; 6'd31: k_rom = 32'h14292967;
      6'd32: k_rom = 32'h27b70a85; 6'd33: k_rom = 32'h2e1b2138; 6'd34: k_rom = 32'h4d2c6dfc; 6'd35: k_rom = 32'h53380d13;
      6'd36: k_rom = 32'h650a7354; 6'd37: k_rom = 32'h766a0abb; 6'd38: k_rom = 32'h81c2c92e; 6'd39: k_rom = 32'h92722c85;
      6'd40: k_rom = 32'ha2bfe8a1; 6'd41: k_rom = 32'ha81a664b; 6'd42: k_rom = 32'hc24b8b70; 6'd43: k_rom = 32'hc76c51a3;
      6'd44: k_rom = 32'hd192e819; 6'd45: k_rom = 32'hd6990624; 6'd46: k_rom = 32'hf40e3585; 6'd47: k_rom = 32'h106aa070;
      6'd48: k_rom = 32'h19a4c116; 6'd49: k_rom = 32'h1e376c08; 6'd50: k_rom = 32'h2748774c; 6'd51: k_rom = 32'h34b0bcb5;
      6'd52: k_rom = 32'h391c0cb3; 6'd53: k_rom = 32'h4ed8aa4a; 6'd54: k_rom = 32'h5b9cca4f; 6'd55: k_rom = 32'h682e6ff3;
      6'd56: k_rom = 32'h748f82ee; 6'd57: k_rom = 32'h78a5636f; 6'd58: k_rom = 32'h84c87814; 6'd59: k_rom = 32'h8cc70208;
      6'd60: k_rom = 32'h90befffa; 6'd61: k_rom = 32'ha4506ceb; 6'd62: k_rom = 32'hbef9a3f7; 6'd63: k_rom = 32'hc67178f2;
      default: k_rom = '0;
    endcase
  endfunction

  assign take       = bus.in_valid && bus.in_ready;
  assign blk_end    = (blk_cnt == 6'd63);
  assign last_chunk = (out_idx == IDX_W'(N_CHUNK - 1));
  assign done       = (state == S_OUTPUT) && bus.out_ready && last_chunk;
  assign shift_en   = take || (state == S_PAD);
  assign len64      = 64'({msg_cnt, 3'b000});
  assign dig        = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};

  // Padding byte: 0x80 once, zeros (all the way to 64 when 0x80 landed late), then length MSB first.
  always_comb begin
    pad_byte = 8'h00;
    if (!p80)
      pad_byte = 8'h80;
    else if (blk_cnt >= 6'd56 && !extra)
      pad_byte = len64[{~blk_cnt[2:0], 3'b000} +: 8];
    sh_byte = (state == S_PAD) ? pad_byte : bus.in_data;
  end

  // One compression round plus the in-place message schedule word.
  always_comb begin
    t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_rom(rnd) + w[0];
    t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
          + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
  end

  // State register; soft_clr overrides every transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      state <= S_IDLE;
    else if (soft_clr) state <= S_IDLE;
    else               state <= nxt;
  end

  // Next-state decode. A 64th byte always closes the block, even with in_last
  // (the pad then follows in a block of its own).
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_LOAD: if (take) nxt = blk_end ? S_ROUND : (bus.in_last ? S_PAD : S_LOAD);
      S_PAD:          if (blk_end) nxt = S_ROUND;
      S_ROUND:        if (rnd == 6'd63) nxt = S_UPDATE;
      S_UPDATE:       nxt = fin ? S_OUTPUT : (extra ? S_PAD : S_LOAD);
      S_OUTPUT:       if (done) nxt = S_IDLE;
      default:        nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; out_data is zero outside OUTPUT.
  always_comb begin
    bus.in_ready  = (state == S_IDLE) || (state == S_LOAD);
    busy          = (state != S_IDLE);
    bus.out_valid = (state == S_OUTPUT);
    bus.out_last  = bus.out_valid && last_chunk;
    bus.out_data  = bus.out_valid ? dig[255 - 32'(out_idx) * OUT_W -: OUT_W] : '0;
  end

  // Hash state, working variables, counters and padding flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        h[i] <= SHA224 ? IV224[i] : IV256[i];
        v[i] <= '0;
      end
      blk_cnt <= '0; msg_cnt <= '0; rnd <= '0; out_idx <= '0;
      p80 <= 1'b0; extra <= 1'b0; fin <= 1'b0;
    end else if (soft_clr || done) begin
      for (int unsigned i = 0; i < 8; i++) h[i] <= SHA224 ? IV224[i] : IV256[i];
      blk_cnt <= '0; msg_cnt <= '0; rnd <= '0; out_idx <= '0;
      p80 <= 1'b0; extra <= 1'b0; fin <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_LOAD: if (take) begin
          blk_cnt <= blk_cnt + 6'd1;
          msg_cnt <= msg_cnt + LEN_W'(1);
          if (blk_end) begin
            // extra here means "pad block still owed" after an aligned in_last
            extra <= bus.in_last;
            rnd   <= '0;
            for (int unsigned i = 0; i < 8; i++) v[i] <= h[i];
          end
        end
        S_PAD: begin
          blk_cnt <= blk_cnt + 6'd1;
          if (!p80) begin
            p80 <= 1'b1;
            if (blk_cnt >= 6'd56) extra <= 1'b1;
          end
          if (blk_end) begin
            fin <= p80 && !extra;
            rnd <= '0;
            for (int unsigned i = 0; i < 8; i++) v[i] <= h[i];
          end
        end
        S_ROUND: begin
          rnd  <= rnd + 6'd1;
          v[0] <= t1 + t2; v[1] <= v[0]; v[2] <= v[1]; v[3] <= v[2];
          v[4] <= v[3] + t1; v[5] <= v[4]; v[6] <= v[5]; v[7] <= v[6];
        end
        S_UPDATE: begin
          for (int unsigned i = 0; i < 8; i++) h[i] <= h[i] + v[i];
          blk_cnt <= '0;
          extra   <= 1'b0;
        end
        S_OUTPUT: if (bus.out_ready) out_idx <= out_idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

  // 16-word window: bytes shift in MSB first; during rounds it rolls and appends W[t+16].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 16; i++) w[i] <= '0;
    end else if (shift_en) begin
      for (int unsigned i = 0; i < 15; i++) w[i] <= {w[i][23:0], w[i+1][31:24]};
      w[15] <= {w[15][23:0], sh_byte};
    end else if (state == S_ROUND) begin
      for (int unsigned i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
    end
  end
endmodule

// File: tb/tb_sha2_stream_core.sv
// Directed bench for sha2_stream_core: SHA-256 byte-chunk instance driven from a
// vector table, SHA-224 word-chunk instance, plus reset / soft_clr sequences.
module tb_sha2_stream_core;
  logic clk = 1'b0;
  logic reset_n, soft_clr, busy_a, busy_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sha2_stream_core_if #(.OUT_W(8))  bus_a ();
  sha2_stream_core_if #(.OUT_W(32)) bus_b ();

  sha2_stream_core #(.OUT_W(8), .SHA224(1'b0), .LEN_W(32)) dut_a (
    .clk(clk), .reset_n(reset_n), .soft_clr(soft_clr), .busy(busy_a), .bus(bus_a.slave));
  sha2_stream_core #(.OUT_W(32), .SHA224(1'b1), .LEN_W(32)) dut_b (
    .clk(clk), .reset_n(reset_n), .soft_clr(soft_clr), .busy(busy_b), .bus(bus_b.slave));

  typedef struct {
    logic [511:0] msg;      // message right-aligned, first byte most significant
    int           len;
    logic [255:0] dig;      // expected digest, H0 at the top
    bit           chk_dig;
    int           lat;      // clock edges from last-byte acceptance to out_valid
    bit           bp;       // apply in_valid noise and an out_ready stall
  } vec_t;

  vec_t tv [5];

  localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_56  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_224 = {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_a(input vec_t v);
    int cyc;
    for (int i = 0; i < v.len; i++) begin
      bus_a.in_data  = v.msg[8*(v.len-1-i) +: 8];
      bus_a.in_valid = 1'b1;
      bus_a.in_last  = (i == v.len - 1);
      cyc = 0;
      while (!bus_a.in_ready && cyc < 300) begin @(posedge clk); #1; cyc++; end
      chk($sformatf("in_ready_byte%0d", i), bus_a.in_ready, 1'b1);
      @(posedge clk); #1;
    end
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  task automatic recv_a(input vec_t v, input string tag);
    int cyc;
    bit saw_ready;
    cyc = 0;
    saw_ready = 1'b0;
    while (!bus_a.out_valid && cyc < 600) begin
      if (v.bp) begin
        bus_a.in_valid = cyc[0];
        bus_a.in_data  = 8'h5a;
        bus_a.in_last  = 1'b1;
        saw_ready |= bus_a.in_ready;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
    chk({tag, "_latency"}, cyc, v.lat);
    if (v.bp) chk({tag, "_in_ready_while_busy"}, saw_ready, 1'b0);
    for (int j = 0; j < 32; j++) begin
      chk($sformatf("%s_valid%0d", tag, j), bus_a.out_valid, 1'b1);
      if (v.chk_dig) chk($sformatf("%s_byte%0d", tag, j), bus_a.out_data, v.dig[255-8*j -: 8]);
      chk($sformatf("%s_last%0d", tag, j), bus_a.out_last, (j == 31));
      if (v.bp && j == 10) begin
        bus_a.out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          chk($sformatf("%s_hold_valid", tag), bus_a.out_valid, 1'b1);
          chk($sformatf("%s_hold_byte", tag), bus_a.out_data, v.dig[255-8*j -: 8]);
        end
        bus_a.out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_idle_valid"}, bus_a.out_valid, 1'b0);
    chk({tag, "_idle_busy"}, busy_a, 1'b0);
  endtask

  task automatic run_a(input vec_t v, input string tag);
    send_a(v);
    recv_a(v, tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy_a"}, busy_a, 1'b0);
    chk({tag, "_valid_a"}, bus_a.out_valid, 1'b0);
    chk({tag, "_data_a"}, bus_a.out_data, 8'h00);
    chk({tag, "_last_a"}, bus_a.out_last, 1'b0);
    chk({tag, "_busy_b"}, busy_b, 1'b0);
    chk({tag, "_valid_b"}, bus_b.out_valid, 1'b0);
    chk({tag, "_data_b"}, bus_b.out_data, 32'h0);
  endtask

  initial begin
    logic [23:0] abc;
    int cyc;
    abc = "abc";
    reset_n = 1'b0; soft_clr = 1'b0;
    bus_a.in_data = '0; bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_data = '0; bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0; bus_b.out_ready = 1'b1;

    tv[0] = '{msg: "abc", len: 3, dig: D_ABC, chk_dig: 1'b1, lat: 126, bp: 1'b0};
    tv[1] = '{msg: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", len: 56,
              dig: D_56, chk_dig: 1'b1, lat: 202, bp: 1'b0};
    tv[2] = '{msg: "abc", len: 3, dig: D_ABC, chk_dig: 1'b1, lat: 126, bp: 1'b1};
    tv[3] = '{msg: "abcdefghabcdefghabcdefghabcdefghabcdefghabcdefghabcdefghabcdefgh", len: 64,
              dig: '0, chk_dig: 1'b0, lat: 194, bp: 1'b0};
    tv[4] = '{msg: "abc", len: 3, dig: D_ABC, chk_dig: 1'b1, lat: 126, bp: 1'b0};

    #12;
    chk_reset_outputs("rst");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready_a", bus_a.in_ready, 1'b1);
    chk("rst_in_ready_b", bus_b.in_ready, 1'b1);

    // SHA-224 with 32-bit chunks: exactly seven words
    for (int i = 0; i < 3; i++) begin
      bus_b.in_data  = abc[8*(2-i) +: 8];
      bus_b.in_valid = 1'b1;
      bus_b.in_last  = (i == 2);
      chk($sformatf("b_in_ready%0d", i), bus_b.in_ready, 1'b1);
      @(posedge clk); #1;
    end
    bus_b.in_valid = 1'b0;
    bus_b.in_last  = 1'b0;
    cyc = 0;
    while (!bus_b.out_valid && cyc < 600) begin @(posedge clk); #1; cyc++; end
    chk("b_latency", cyc, 126);
    for (int j = 0; j < 7; j++) begin
      chk($sformatf("b_valid%0d", j), bus_b.out_valid, 1'b1);
      chk($sformatf("b_word%0d", j), bus_b.out_data, D_224[255-32*j -: 32]);
      chk($sformatf("b_last%0d", j), bus_b.out_last, (j == 6));
      @(posedge clk); #1;
    end
    chk("b_no_8th_word", bus_b.out_valid, 1'b0);
    chk("b_idle_busy", busy_b, 1'b0);

    // SHA-256 vector table
    for (int k = 0; k < 5; k++) run_a(tv[k], $sformatf("v%0d", k));

    // asynchronous reset in the middle of the round phase
    send_a(tv[0]);
    repeat (70) @(posedge clk);
    chk("mid_round_busy", busy_a, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_in_ready", bus_a.in_ready, 1'b1);
    run_a(tv[0], "after_arst");

    // soft_clr while loading; the byte offered alongside it must be dropped
    bus_a.in_valid = 1'b1; bus_a.in_last = 1'b0; bus_a.in_data = 8'h61;
    @(posedge clk); #1;
    bus_a.in_data = 8'h62;
    @(posedge clk); #1;
    chk("load_busy", busy_a, 1'b1);
    soft_clr = 1'b1; bus_a.in_data = 8'h63; bus_a.in_last = 1'b1;
    @(posedge clk); #1;
    soft_clr = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
    chk_reset_outputs("sclr");
    chk("sclr_in_ready", bus_a.in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("sclr_byte_dropped", busy_a, 1'b0);
    run_a(tv[0], "after_sclr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
